// File: rtl/isa_dma_scheduler.sv
// ISA bus scheduler: arbitrates HPS PIO against DRQ1/3/5/7, drives DACK/AEN,
// launches single DMA cycles and tracks per-channel transfer counts.
module isa_dma_scheduler #(
    parameter int SETUP_CYCLES = 2,
    parameter int TIMEOUT      = 1024
) (
    input  logic        clk_i,
    input  logic        reset_ni,
    input  logic [3:0]  drq_i,
    input  logic [3:0]  chan_en_i,
    input  logic        cfg_we_i,
    input  logic [1:0]  cfg_chan_i,
    input  logic [15:0] cfg_count_i,
    input  logic        pio_req_i,
    input  logic        pio_done_i,
    output logic        pio_gnt_o,
    input  logic        dma_done_i,
    output logic        dma_start_o,
    output logic [1:0]  dma_chan_o,
    output logic [3:0]  dack_n_o,
    output logic        aen_o,
    output logic        tc_o,
    output logic [1:0]  tc_chan_o,
    output logic        err_o,
    output logic        busy_o,
    output logic [2:0]  state_out_o
);

    // state   | meaning
    // IDLE    | bus free, arbitrate PIO vs DMA
    // PIO     | bus granted to HPS, wait for pio_done
    // SETUP   | DACK/AEN asserted, counting setup cycles
    // XFER    | DMA cycle launched, wait for dma_done or timeout
    // RELEASE | one cycle with DACK/AEN inactive
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_PIO     = 3'd1,
        S_SETUP   = 3'd2,
        S_XFER    = 3'd3,
        S_RELEASE = 3'd4
    } state_t;

    localparam int SW = (SETUP_CYCLES > 1) ? $clog2(SETUP_CYCLES) : 1;
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [SW-1:0] SETUP_LOAD = SW'(SETUP_CYCLES - 1);
    localparam logic [TW-1:0] TMO_LOAD   = TW'(TIMEOUT - 1);

    state_t        state_q;
    logic [1:0]    last_chan_q;
    logic          last_was_pio_q;
    logic [1:0]    dma_chan_q;
    logic [15:0]   count_q [4];
    logic [SW-1:0] setup_cnt_q;
    logic [TW-1:0] tmo_cnt_q;
    logic          pio_gnt_q;
    logic          dma_start_q;
    logic [3:0]    dack_n_q;
    logic          aen_q;
    logic          tc_q;
    logic [1:0]    tc_chan_q;
    logic          err_q;
    logic          busy_q;

    logic [3:0] elig;
    logic       grant_vld;
    logic [1:0] grant_chan;
    logic [1:0] cand;

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            elig[i] = drq_i[i] & chan_en_i[i] & (count_q[i] != 16'd0);
        end
    end

    // Scan from the farthest offset down so the nearest eligible channel after
    // last_chan is the one that sticks.
    always_comb begin
        grant_vld  = 1'b0;
        grant_chan = last_chan_q;
        cand       = last_chan_q;
        for (int i = 4; i >= 1; i--) begin
            cand = last_chan_q + 2'(i);
            if (elig[cand]) begin
                grant_vld  = 1'b1;
                grant_chan = cand;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            state_q        <= S_IDLE;
            last_chan_q    <= 2'd3;
            last_was_pio_q <= 1'b0;
            dma_chan_q     <= 2'd0;
            for (int i = 0; i < 4; i++) count_q[i] <= 16'd0;
            setup_cnt_q    <= '0;
            tmo_cnt_q      <= '0;
            pio_gnt_q      <= 1'b0;
            dma_start_q    <= 1'b0;
            dack_n_q       <= 4'hF;
            aen_q          <= 1'b0;
            tc_q           <= 1'b0;
            tc_chan_q      <= 2'd0;
            err_q          <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            dma_start_q <= 1'b0;
            tc_q        <= 1'b0;
            err_q       <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (pio_req_i && (!grant_vld || !last_was_pio_q)) begin
                        state_q        <= S_PIO;
                        pio_gnt_q      <= 1'b1;
                        last_was_pio_q <= 1'b1;
                        busy_q         <= 1'b1;
                    end else if (grant_vld) begin
                        state_q        <= S_SETUP;
                        dma_chan_q     <= grant_chan;
                        last_chan_q    <= grant_chan;
                        last_was_pio_q <= 1'b0;
                        dack_n_q       <= ~(4'b0001 << grant_chan);
                        aen_q          <= 1'b1;
                        setup_cnt_q    <= SETUP_LOAD;
                        busy_q         <= 1'b1;
                    end
                end
                S_PIO: begin
                    if (pio_done_i) begin
                        state_q   <= S_IDLE;
                        pio_gnt_q <= 1'b0;
                        busy_q    <= 1'b0;
                    end
                end
                S_SETUP: begin
                    if (!drq_i[dma_chan_q]) begin
                        state_q  <= S_RELEASE;
                        dack_n_q <= 4'hF;
                        aen_q    <= 1'b0;
                    end else if (setup_cnt_q == '0) begin
                        state_q     <= S_XFER;
                        dma_start_q <= 1'b1;
                        tmo_cnt_q   <= TMO_LOAD;
                    end else begin
                        setup_cnt_q <= setup_cnt_q - SW'(1);
                    end
                end
                S_XFER: begin
                    if (dma_done_i) begin
                        state_q   <= S_RELEASE;
                        dack_n_q  <= 4'hF;
                        aen_q     <= 1'b0;
                        tmo_cnt_q <= '0;
                        if (count_q[dma_chan_q] != 16'd0) begin
                            count_q[dma_chan_q] <= count_q[dma_chan_q] - 16'd1;
                            // A same-channel config write overrides the decrement below.
                            if (count_q[dma_chan_q] == 16'd1 &&
                                !(cfg_we_i && cfg_chan_i == dma_chan_q)) begin
                                tc_q      <= 1'b1;
                                tc_chan_q <= dma_chan_q;
                            end
                        end
                    end else if (tmo_cnt_q == '0) begin
                        state_q  <= S_RELEASE;
                        err_q    <= 1'b1;
                        dack_n_q <= 4'hF;
                        aen_q    <= 1'b0;
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q - TW'(1);
                    end
                end
                S_RELEASE: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q   <= S_IDLE;
                    busy_q    <= 1'b0;
                    dack_n_q  <= 4'hF;
                    aen_q     <= 1'b0;
                    pio_gnt_q <= 1'b0;
                end
            endcase
            if (cfg_we_i) count_q[cfg_chan_i] <= cfg_count_i;
        end
    end

    assign pio_gnt_o   = pio_gnt_q;
    assign dma_start_o = dma_start_q;
    assign dma_chan_o  = dma_chan_q;
    assign dack_n_o    = dack_n_q;
    assign aen_o       = aen_q;
    assign tc_o        = tc_q;
    assign tc_chan_o   = tc_chan_q;
    assign err_o       = err_q;
    assign busy_o      = busy_q;
    assign state_out_o = state_q;

endmodule

// File: tb/tb_isa_dma_scheduler.sv
// Directed bench for isa_dma_scheduler: arbitration order, setup/launch timing,
// terminal count, SETUP abort, timeout, mid-transfer reset and cfg/decrement collision.
module tb_isa_dma_scheduler;

    localparam int SETUP = 2;
    localparam int TMO   = 16;

    logic        clk;
    logic        reset_n;
    logic [3:0]  drq;
    logic [3:0]  chan_en;
    logic        cfg_we;
    logic [1:0]  cfg_chan;
    logic [15:0] cfg_count;
    logic        pio_req;
    logic        pio_done;
    logic        pio_gnt_o;
    logic        dma_done;
    logic        dma_start_o;
    logic [1:0]  dma_chan_o;
    logic [3:0]  dack_n_o;
    logic        aen_o;
    logic        tc_o;
    logic [1:0]  tc_chan_o;
    logic        err_o;
    logic        busy_o;
    logic [2:0]  state_out_o;

    isa_dma_scheduler #(.SETUP_CYCLES(SETUP), .TIMEOUT(TMO)) dut (
        .clk_i(clk), .reset_ni(reset_n), .drq_i(drq), .chan_en_i(chan_en),
        .cfg_we_i(cfg_we), .cfg_chan_i(cfg_chan), .cfg_count_i(cfg_count),
        .pio_req_i(pio_req), .pio_done_i(pio_done), .pio_gnt_o(pio_gnt_o),
        .dma_done_i(dma_done), .dma_start_o(dma_start_o), .dma_chan_o(dma_chan_o),
        .dack_n_o(dack_n_o), .aen_o(aen_o), .tc_o(tc_o), .tc_chan_o(tc_chan_o),
        .err_o(err_o), .busy_o(busy_o), .state_out_o(state_out_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_chk  = 0;
    int n_fail = 0;

    task automatic expect_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Event log filled by the monitor; 4 marks a PIO grant.
    int   grant_q[$];
    logic [3:0] dack_q[$];
    int   off_q[$];
    int   tc_q[$];
    int   cyc = 0;
    int   last_grant = 0;
    int   start_cyc = 0;
    int   tc_cyc = 0;
    int   n_start = 0;
    int   viol_overlap = 0;
    int   viol_dack = 0;
    logic auto_done = 1'b1;

    function automatic int dack_chan(input logic [3:0] d);
        for (int i = 0; i < 4; i++) if (!d[i]) return i;
        return 7;
    endfunction

    // Monitor plus dma_done / pio_done responders, all sampled at negedge.
    initial begin
        logic aen_prev;
        logic gnt_prev;
        int   pio_cnt;
        aen_prev = 1'b0;
        gnt_prev = 1'b0;
        pio_cnt  = 0;
        dma_done = 1'b0;
        pio_done = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            if (aen_o === 1'b1 && !aen_prev) begin
                grant_q.push_back(dack_chan(dack_n_o));
                dack_q.push_back(dack_n_o);
                last_grant = cyc;
            end
            if (pio_gnt_o === 1'b1 && !gnt_prev) grant_q.push_back(4);
            if (dma_start_o === 1'b1) begin
                off_q.push_back(cyc - last_grant);
                start_cyc = cyc;
                n_start++;
            end
            if (tc_o === 1'b1) begin
                tc_q.push_back(int'(tc_chan_o));
                tc_cyc = cyc;
            end
            if (pio_gnt_o === 1'b1 && aen_o === 1'b1) viol_overlap++;
            if (reset_n === 1'b1 && cyc > 3) begin
                if ($countones(~dack_n_o) > 1) viol_dack++;
                if (aen_o !== ($countones(~dack_n_o) == 1)) viol_dack++;
            end
            aen_prev = (aen_o === 1'b1);
            gnt_prev = (pio_gnt_o === 1'b1);
            dma_done = auto_done && (dma_start_o === 1'b1);
            pio_done = 1'b0;
            if (pio_gnt_o === 1'b1) begin
                pio_cnt++;
                if (pio_cnt == 2) begin
                    pio_done = 1'b1;
                    pio_cnt  = 0;
                end
            end else begin
                pio_cnt = 0;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clr();
        grant_q.delete(); dack_q.delete(); off_q.delete(); tc_q.delete();
        n_start = 0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0; drq = 4'h0; pio_req = 1'b0; cfg_we = 1'b0; auto_done = 1'b1;
        tick(2);
        reset_n = 1'b1;
        tick(1);
    endtask

    task automatic cfg(input logic [1:0] ch, input logic [15:0] val);
        cfg_we = 1'b1; cfg_chan = ch; cfg_count = val;
        tick(1);
        cfg_we = 1'b0;
    endtask

    task automatic wait_start(input string tag, input int bound);
        int k = 0;
        while (dma_start_o !== 1'b1 && k < bound) begin tick(1); k++; end
        expect_eq(tag, dma_start_o, 1);
    endtask

    initial begin
        int k;
        reset_n = 1'b0; drq = 4'h0; chan_en = 4'h0; cfg_we = 1'b0;
        cfg_chan = 2'd0; cfg_count = 16'd0; pio_req = 1'b0;

        // Reset values
        tick(3);
        expect_eq("rst_pio_gnt", pio_gnt_o, 0);
        expect_eq("rst_dma_start", dma_start_o, 0);
        expect_eq("rst_dma_chan", dma_chan_o, 0);
        expect_eq("rst_dack_n", dack_n_o, 4'hF);
        expect_eq("rst_aen", aen_o, 0);
        expect_eq("rst_tc", tc_o, 0);
        expect_eq("rst_tc_chan", tc_chan_o, 0);
        expect_eq("rst_err", err_o, 0);
        expect_eq("rst_busy", busy_o, 0);
        expect_eq("rst_state", state_out_o, 0);

        // Single channel, three transfers then terminal count
        do_reset();
        chan_en = 4'h2;
        cfg(2'd1, 16'd3);
        clr();
        drq = 4'h2;
        tick(40);
        expect_eq("t1_grants", grant_q.size(), 3);
        for (int i = 0; i < grant_q.size(); i++) expect_eq("t1_chan", grant_q[i], 1);
        for (int i = 0; i < dack_q.size(); i++) expect_eq("t1_dack", dack_q[i], 4'b1101);
        expect_eq("t1_starts", n_start, 3);
        for (int i = 0; i < off_q.size(); i++) expect_eq("t1_start_ofs", off_q[i], SETUP);
        expect_eq("t1_tc_count", tc_q.size(), 1);
        if (tc_q.size() > 0) expect_eq("t1_tc_chan", tc_q[0], 1);
        expect_eq("t1_tc_after_done", tc_cyc - start_cyc, 1);
        drq = 4'h0;

        // Round-robin across all four channels
        do_reset();
        chan_en = 4'hF;
        for (int c = 0; c < 4; c++) cfg(2'(c), 16'd2);
        clr();
        drq = 4'hF;
        tick(60);
        expect_eq("t2_grants", grant_q.size(), 8);
        for (int i = 0; i < grant_q.size(); i++) expect_eq("t2_order", grant_q[i], i % 4);
        expect_eq("t2_tc_count", tc_q.size(), 4);
        for (int i = 0; i < tc_q.size(); i++) expect_eq("t2_tc_order", tc_q[i], i);
        drq = 4'h0;

        // PIO / DMA alternation
        do_reset();
        chan_en = 4'h1;
        cfg(2'd0, 16'd2);
        clr();
        pio_req = 1'b1; drq = 4'h1;
        tick(40);
        pio_req = 1'b0; drq = 4'h0;
        tick(10);
        expect_eq("t3_enough_events", grant_q.size() >= 5, 1);
        if (grant_q.size() >= 5) begin
            expect_eq("t3_ev0_pio", grant_q[0], 4);
            expect_eq("t3_ev1_ch0", grant_q[1], 0);
            expect_eq("t3_ev2_pio", grant_q[2], 4);
            expect_eq("t3_ev3_ch0", grant_q[3], 0);
            expect_eq("t3_ev4_pio", grant_q[4], 4);
        end

        // DRQ drop during SETUP aborts without a transfer
        do_reset();
        chan_en = 4'h4;
        cfg(2'd2, 16'd1);
        clr();
        drq = 4'h4;
        k = 0;
        while (aen_o !== 1'b1 && k < 10) begin tick(1); k++; end
        expect_eq("t4_grant", aen_o, 1);
        expect_eq("t4_dack", dack_n_o, 4'b1011);
        drq = 4'h0;
        tick(1);
        expect_eq("t4_rel_aen", aen_o, 0);
        expect_eq("t4_rel_dack", dack_n_o, 4'hF);
        expect_eq("t4_rel_state", state_out_o, 4);
        tick(1);
        expect_eq("t4_idle_state", state_out_o, 0);
        expect_eq("t4_no_start", n_start, 0);
        drq = 4'h4;
        tick(20);
        expect_eq("t4_retry_start", n_start, 1);
        expect_eq("t4_retry_tc", tc_q.size(), 1);
        if (tc_q.size() > 0) expect_eq("t4_tc_chan", tc_q[0], 2);
        drq = 4'h0;

        // Timeout on a withheld dma_done
        do_reset();
        chan_en = 4'h8;
        cfg(2'd3, 16'd2);
        clr();
        auto_done = 1'b0;
        drq = 4'h8;
        wait_start("t5_start", 20);
        drq = 4'h0;
        k = 0;
        while (err_o !== 1'b1 && k < 40) begin tick(1); k++; end
        expect_eq("t5_err_delay", k, TMO);
        expect_eq("t5_err_aen", aen_o, 0);
        expect_eq("t5_err_dack", dack_n_o, 4'hF);
        expect_eq("t5_err_state", state_out_o, 4);
        tick(1);
        expect_eq("t5_err_pulse", err_o, 0);
        auto_done = 1'b1;
        drq = 4'h8;
        tick(25);
        expect_eq("t5_starts_total", n_start, 3);
        expect_eq("t5_tc_count", tc_q.size(), 1);
        if (tc_q.size() > 0) expect_eq("t5_tc_chan", tc_q[0], 3);
        drq = 4'h0;

        // Reset asserted mid-XFER
        do_reset();
        chan_en = 4'h1;
        cfg(2'd0, 16'd5);
        clr();
        auto_done = 1'b0;
        drq = 4'h1;
        wait_start("t6_start", 20);
        reset_n = 1'b0;
        tick(1);
        expect_eq("t6_dack", dack_n_o, 4'hF);
        expect_eq("t6_aen", aen_o, 0);
        expect_eq("t6_busy", busy_o, 0);
        expect_eq("t6_state", state_out_o, 0);
        expect_eq("t6_start", dma_start_o, 0);
        reset_n = 1'b1;
        auto_done = 1'b1;
        clr();
        tick(20);
        expect_eq("t6_counts_cleared", grant_q.size(), 0);
        drq = 4'h0;

        // Config write colliding with the final decrement
        do_reset();
        chan_en = 4'h2;
        cfg(2'd1, 16'd1);
        clr();
        drq = 4'h2;
        wait_start("t7_start", 20);
        cfg_we = 1'b1; cfg_chan = 2'd1; cfg_count = 16'd3;
        tick(1);
        cfg_we = 1'b0;
        expect_eq("t7_no_tc", tc_o, 0);
        expect_eq("t7_rel_state", state_out_o, 4);
        tick(40);
        expect_eq("t7_starts", n_start, 4);
        expect_eq("t7_tc_count", tc_q.size(), 1);
        if (tc_q.size() > 0) expect_eq("t7_tc_chan", tc_q[0], 1);
        drq = 4'h0;
        tick(5);

        expect_eq("inv_pio_aen_overlap", viol_overlap, 0);
        expect_eq("inv_aen_dack", viol_dack, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
